// File: rtl/dso_cmd_seq_pkg.sv
// dso_cmd_pkg: shared types and constants for the DSO host-command sequencer.
//   state_e        sequencer FSM states
//   entry layout   script entry = {n_resp_m1, mask, exp, cmd}, LSB first
//   ACK/NAK        canonical UART-master response bytes
//   opcodes        host command opcodes (top byte of cmd)
package dso_cmd_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_SEND,
        S_WAIT_SENT,
        S_WAIT_RESP,
        S_CHECK,
        S_NEXT,
        S_DONE
    } state_e;

    // Width of the "extra response bytes" field at the top of an entry.
    localparam int NRESP_W = 8;

    // Field offsets inside an entry for a given command/response width.
    function automatic int exp_lsb(input int cmd_w);
        return cmd_w;
    endfunction

    function automatic int mask_lsb(input int cmd_w, input int resp_w);
        return cmd_w + resp_w;
    endfunction

    function automatic int nresp_lsb(input int cmd_w, input int resp_w);
        return cmd_w + 2 * resp_w;
    endfunction

    localparam logic [7:0] ACK = 8'hA5;
    localparam logic [7:0] NAK = 8'hEE;

    localparam logic [7:0] DUMP_CH      = 8'h01;
    localparam logic [7:0] CFG_GAIN     = 8'h02;
    localparam logic [7:0] CFG_TRG_LVL  = 8'h03;
    localparam logic [7:0] CFG_TRG_POS  = 8'h04;
    localparam logic [7:0] CFG_TRG_CTRL = 8'h05;
    localparam logic [7:0] CFG_DECIM    = 8'h06;
    localparam logic [7:0] CFG_OFFSET   = 8'h07;
    localparam logic [7:0] EEP_WR       = 8'h08;
    localparam logic [7:0] EEP_RD       = 8'h09;

endpackage

// File: rtl/dso_cmd_seq_mem.sv
// dso_cmd_seq_mem: DEPTH x W script RAM, one write and one read port.
//   clk            clock
//   we/waddr/wdata synchronous write
//   re/raddr       read request; rdata valid the cycle after, held otherwise
module dso_cmd_seq_mem #(
    parameter int DEPTH = 16,
    parameter int W     = 48,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem_q [DEPTH];
    logic [W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) mem_q[waddr] <= wdata;
        if (re) rdata_q <= mem_q[raddr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/dso_cmd_seq.sv
// dso_cmd_seq: scripted host-command sequencer for the DSO UART master.
//   prog_*        script programming (ignored while busy)
//   run_len/start/stop_on_fail   run control
//   cmd/send_cmd/cmd_sent        command handshake with the UART master
//   resp/resp_rdy/clr_resp_rdy   response handshake with the UART master
//   busy/done/pass_cnt/fail_cnt/first_fail/fail_vld/timeout   results
module dso_cmd_seq
    import dso_cmd_pkg::*;
#(
    parameter int CMD_W  = 24,
    parameter int RESP_W = 8,
    parameter int DEPTH  = 16,
    parameter int TO_W   = 20,
    localparam int AW    = $clog2(DEPTH),
    localparam int ENT_W = CMD_W + 2 * RESP_W + NRESP_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              prog_we,
    input  logic [AW-1:0]     prog_addr,
    input  logic [ENT_W-1:0]  prog_data,
    input  logic [AW:0]       run_len,
    input  logic              stop_on_fail,
    input  logic              start,
    output logic [CMD_W-1:0]  cmd,
    output logic              send_cmd,
    input  logic              cmd_sent,
    input  logic              resp_rdy,
    input  logic [RESP_W-1:0] resp,
    output logic              clr_resp_rdy,
    output logic              busy,
    output logic              done,
    output logic [AW:0]       pass_cnt,
    output logic [AW:0]       fail_cnt,
    output logic [AW-1:0]     first_fail,
    output logic              fail_vld,
    output logic              timeout
);

    localparam int EXP_LSB  = exp_lsb(CMD_W);
    localparam int MASK_LSB = mask_lsb(CMD_W, RESP_W);
    localparam int NR_LSB   = nresp_lsb(CMD_W, RESP_W);

    localparam logic [TO_W-1:0] TO_LOAD = '1;
    localparam logic [TO_W-1:0] TO_ONE  = 1;
    localparam logic [AW:0]     CNT_ONE = 1;
    localparam logic [AW-1:0]   IDX_ONE = 1;
    localparam logic [AW-1:0]   IDX_MAX = AW'(DEPTH - 1);

    logic [ENT_W-1:0]   rd_data;
    logic               ram_re;
    logic [CMD_W-1:0]   ent_cmd;
    logic [RESP_W-1:0]  ent_exp, ent_mask;
    logic [NRESP_W-1:0] ent_nrm1;
    logic               mismatch, fail_now, last_ent;

    state_e             state_q, state_d;
    logic [AW-1:0]      idx_q, idx_d, first_fail_q, first_fail_d;
    logic [AW:0]        run_len_q, run_len_d, pass_q, pass_d, fail_q, fail_d;
    logic [NRESP_W-1:0] byte_cnt_q, byte_cnt_d;
    logic [TO_W-1:0]    timer_q, timer_d;
    logic [CMD_W-1:0]   cmd_q, cmd_d;
    logic send_q, send_d, clr_q, clr_d, busy_q, busy_d, done_q, done_d;
    logic fvld_q, fvld_d, to_q, to_d, ent_fail_q, ent_fail_d;
    logic first_q, first_d, sof_q, sof_d;

    // The RAM output is only refreshed in FETCH, so the entry fields stay
    // stable for the whole lifetime of an entry.
    dso_cmd_seq_mem #(.DEPTH(DEPTH), .W(ENT_W)) u_mem (
        .clk   (clk),
        .we    (prog_we & ~busy_q),
        .waddr (prog_addr),
        .wdata (prog_data),
        .re    (ram_re),
        .raddr (idx_q),
        .rdata (rd_data)
    );

    assign ent_cmd  = rd_data[CMD_W-1:0];
    assign ent_exp  = rd_data[EXP_LSB +: RESP_W];
    assign ent_mask = rd_data[MASK_LSB +: RESP_W];
    assign ent_nrm1 = rd_data[NR_LSB +: NRESP_W];

    // Only the first response byte of an entry is compared.
    assign mismatch = (resp & ent_mask) != (ent_exp & ent_mask);
    assign fail_now = ent_fail_q | (first_q & mismatch);
    // The DEPTH-1 guard stops an oversized run_len from wrapping idx.
    assign last_ent = ({1'b0, idx_q} == (run_len_q - CNT_ONE)) || (idx_q == IDX_MAX);

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        first_fail_d = first_fail_q;
        run_len_d    = run_len_q;
        pass_d       = pass_q;
        fail_d       = fail_q;
        byte_cnt_d   = byte_cnt_q;
        timer_d      = timer_q;
        cmd_d        = cmd_q;
        busy_d       = busy_q;
        done_d       = done_q;
        fvld_d       = fvld_q;
        to_d         = to_q;
        ent_fail_d   = ent_fail_q;
        first_d      = first_q;
        sof_d        = sof_q;
        send_d       = 1'b0;
        clr_d        = 1'b0;
        ram_re       = 1'b0;

        case (state_q)
            S_IDLE: if (start) begin
                pass_d       = '0;
                fail_d       = '0;
                fvld_d       = 1'b0;
                first_fail_d = '0;
                to_d         = 1'b0;
                if (run_len == '0) begin
                    done_d = 1'b1;
                end else begin
                    done_d    = 1'b0;
                    busy_d    = 1'b1;
                    idx_d     = '0;
                    run_len_d = run_len;
                    sof_d     = stop_on_fail;
                    state_d   = S_FETCH;
                end
            end
            S_FETCH: begin
                ram_re  = 1'b1;
                state_d = S_SEND;
            end
            S_SEND: begin
                cmd_d      = ent_cmd;
                send_d     = 1'b1;
                byte_cnt_d = ent_nrm1;
                ent_fail_d = 1'b0;
                first_d    = 1'b1;
                state_d    = S_WAIT_SENT;
            end
            S_WAIT_SENT: if (cmd_sent) begin
                timer_d = TO_LOAD;
                state_d = S_WAIT_RESP;
            end
            S_WAIT_RESP: begin
                if (resp_rdy) begin
                    clr_d   = 1'b1;   // high during CHECK
                    state_d = S_CHECK;
                end else if (timer_q == '0) begin
                    fail_d     = fail_q + CNT_ONE;
                    to_d       = 1'b1;
                    ent_fail_d = 1'b1;
                    if (!fvld_q) begin
                        fvld_d       = 1'b1;
                        first_fail_d = idx_q;
                    end
                    state_d = S_NEXT;
                end else begin
                    timer_d = timer_q - TO_ONE;
                end
            end
            S_CHECK: begin
                first_d    = 1'b0;
                ent_fail_d = fail_now;
                if (byte_cnt_q != '0) begin
                    byte_cnt_d = byte_cnt_q - 1'b1;
                    timer_d    = TO_LOAD;
                    state_d    = S_WAIT_RESP;
                end else begin
                    state_d = S_NEXT;
                    if (fail_now) begin
                        fail_d = fail_q + CNT_ONE;
                        if (!fvld_q) begin
                            fvld_d       = 1'b1;
                            first_fail_d = idx_q;
                        end
                    end else begin
                        pass_d = pass_q + CNT_ONE;
                    end
                end
            end
            S_NEXT: begin
                if ((ent_fail_q && sof_q) || last_ent) begin
                    state_d = S_DONE;
                end else begin
                    idx_d   = idx_q + IDX_ONE;
                    state_d = S_FETCH;
                end
            end
            S_DONE: begin
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            idx_q        <= '0;
            first_fail_q <= '0;
            run_len_q    <= '0;
            pass_q       <= '0;
            fail_q       <= '0;
            byte_cnt_q   <= '0;
            timer_q      <= '0;
            cmd_q        <= '0;
            send_q       <= 1'b0;
            clr_q        <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            fvld_q       <= 1'b0;
            to_q         <= 1'b0;
            ent_fail_q   <= 1'b0;
            first_q      <= 1'b0;
            sof_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            first_fail_q <= first_fail_d;
            run_len_q    <= run_len_d;
            pass_q       <= pass_d;
            fail_q       <= fail_d;
            byte_cnt_q   <= byte_cnt_d;
            timer_q      <= timer_d;
            cmd_q        <= cmd_d;
            send_q       <= send_d;
            clr_q        <= clr_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            fvld_q       <= fvld_d;
            to_q         <= to_d;
            ent_fail_q   <= ent_fail_d;
            first_q      <= first_d;
            sof_q        <= sof_d;
        end
    end

    assign cmd          = cmd_q;
    assign send_cmd     = send_q;
    assign clr_resp_rdy = clr_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign pass_cnt     = pass_q;
    assign fail_cnt     = fail_q;
    assign first_fail   = first_fail_q;
    assign fail_vld     = fvld_q;
    assign timeout      = to_q;

endmodule
